// File: rtl/plc_pkg.sv
// Shared types and sizing helpers for the PLC receive-side deserializer.
package plc_pkg;

  typedef enum logic [1:0] {HUNT, SHIFT, GAP} state_t;

  // The counter has to reach the larger of the data and gap lengths.
  function automatic int cnt_width(input int data_bits, input int gap_bits);
    int m;
    m = (data_bits > gap_bits) ? data_bits : gap_bits;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/plc_out_hold.sv
// Output holding register with a valid/ready handshake and an overrun pulse.
module plc_out_hold
  import plc_pkg::*;
#(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 commit,
  input  logic [DATA_BITS-1:0] word,
  input  logic                 prl_ready,
  output logic [DATA_BITS-1:0] prl_out,
  output logic                 prl_valid,
  output logic                 overrun
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prl_out   <= '0;
      prl_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (commit) begin
      // A commit wins over a same-edge consume; only an unread word is lost.
      prl_out   <= word;
      prl_valid <= 1'b1;
      overrun   <= prl_valid && !prl_ready;
    end else begin
      overrun <= 1'b0;
      if (prl_valid && prl_ready) begin
        prl_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/deserializer.sv
// LSB-first serial-to-parallel receiver: frame_sync alignment, gap-bit
// checking and free-running back-to-back framing.
module deserializer
  import plc_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int GAP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 srl_in,
  input  logic                 frame_sync,
  output logic [DATA_BITS-1:0] prl_out,
  output logic                 prl_valid,
  input  logic                 prl_ready,
  output logic                 locked,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CNT_W = cnt_width(DATA_BITS, GAP_BITS);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_GAP  = CNT_W'(GAP_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 err, err_n;
  logic                 locked_n;
  logic                 frame_err_n;
  logic                 commit;
  logic                 err_now;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      cnt       <= '0;
      shreg     <= '0;
      err       <= 1'b0;
      locked    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      shreg     <= shreg_n;
      err       <= err_n;
      locked    <= locked_n;
      frame_err <= frame_err_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    shreg_n     = shreg;
    err_n       = err;
    locked_n    = locked;
    frame_err_n = 1'b0;
    commit      = 1'b0;
    err_now     = err | srl_in;

    if (frame_sync) begin
      // A strobe in any state restarts the word; a partial word is dropped silently.
      shreg_n    = '0;
      shreg_n[0] = srl_in;
      err_n      = 1'b0;
      locked_n   = 1'b1;
      if (DATA_BITS == 1) begin
        state_n = GAP;
        cnt_n   = '0;
      end else begin
        state_n = SHIFT;
        cnt_n   = CNT_ONE;
      end
    end else begin
      case (state)
        SHIFT: begin
          for (int i = 0; i < DATA_BITS; i++) begin
            if (int'(cnt) == i) shreg_n[i] = srl_in;
          end
          if (cnt == LAST_DATA) begin
            state_n = GAP;
            cnt_n   = '0;
            err_n   = 1'b0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == LAST_GAP) begin
            commit      = !err_now;
            frame_err_n = err_now;
            state_n     = SHIFT;
            cnt_n       = '0;
            err_n       = 1'b0;
          end else begin
            cnt_n = cnt + 1'b1;
            err_n = err_now;
          end
        end
        default: ;
      endcase
    end
  end

  plc_out_hold #(
    .DATA_BITS(DATA_BITS)
  ) u_out_hold (
    .clk      (clk),
    .rst_n    (rst_n),
    .commit   (commit),
    .word     (shreg),
    .prl_ready(prl_ready),
    .prl_out  (prl_out),
    .prl_valid(prl_valid),
    .overrun  (overrun)
  );

endmodule

// File: tb/tb_deserializer.sv
// Directed bench for deserializer with DATA_BITS=8, GAP_BITS=1.
module tb_deserializer;

  logic       clk;
  logic       rst_n;
  logic       srl_in;
  logic       frame_sync;
  logic [7:0] prl_out;
  logic       prl_valid;
  logic       prl_ready;
  logic       locked;
  logic       frame_err;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  deserializer #(.DATA_BITS(8), .GAP_BITS(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .srl_in    (srl_in),
    .frame_sync(frame_sync),
    .prl_out   (prl_out),
    .prl_valid (prl_valid),
    .prl_ready (prl_ready),
    .locked    (locked),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       gap;
    logic       ready;
    logic       exp_valid;
    logic [7:0] exp_out;
    logic       exp_err;
    logic       exp_ovr;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send_bit(input logic b, input logic sync);
    srl_in     = b;
    frame_sync = sync;
    @(posedge clk);
    #1;
    frame_sync = 1'b0;
  endtask

  task automatic send_rest(input logic [7:0] data, input logic gap);
    for (int k = 1; k < 8; k++) send_bit(data[k], 1'b0);
    send_bit(gap, 1'b0);
  endtask

  initial begin
    logic prev_valid;
    logic prev_ready;

    vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0};
    vecs[2] = '{8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[3] = '{8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{8'h12, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[5] = '{8'h34, 1'b0, 1'b1, 1'b1, 8'h34, 1'b0, 1'b0};
    vecs[6] = '{8'h11, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0};
    vecs[7] = '{8'h22, 1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 1'b1};

    rst_n      = 1'b0;
    srl_in     = 1'b1;
    frame_sync = 1'b0;
    prl_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out",   prl_out,   0);
    check("reset_valid", prl_valid, 0);
    check("reset_lock",  locked,    0);
    check("reset_ferr",  frame_err, 0);
    check("reset_ovr",   overrun,   0);
    rst_n = 1'b1;

    // HUNT ignores the line until the first strobe.
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    check("hunt_lock",  locked,    0);
    check("hunt_valid", prl_valid, 0);

    prev_valid = 1'b0;
    prev_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_bit(vecs[i].data[0], i == 0);
      check($sformatf("v%0d_b0_valid", i), prl_valid, prev_valid && !prev_ready);
      check($sformatf("v%0d_b0_ferr", i), frame_err, 0);
      check($sformatf("v%0d_b0_ovr", i), overrun, 0);
      check($sformatf("v%0d_lock", i), locked, 1);
      prl_ready = vecs[i].ready;
      for (int k = 1; k < 8; k++) send_bit(vecs[i].data[k], 1'b0);
      if (i == 0) check("v0_no_early_valid", prl_valid, 0);
      send_bit(vecs[i].gap, 1'b0);
      check($sformatf("v%0d_valid", i), prl_valid, vecs[i].exp_valid);
      check($sformatf("v%0d_out", i),   prl_out,   vecs[i].exp_out);
      check($sformatf("v%0d_ferr", i),  frame_err, vecs[i].exp_err);
      check($sformatf("v%0d_ovr", i),   overrun,   vecs[i].exp_ovr);
      prev_valid = vecs[i].exp_valid;
      prev_ready = vecs[i].ready;
    end

    // Raising ready drains the overwritten word.
    prl_ready = 1'b1;
    send_bit(1'b0, 1'b0);
    check("drain_valid", prl_valid, 0);
    check("drain_ovr",   overrun,   0);
    check("drain_out",   prl_out,   8'h22);

    // Resync at data bit 4: the partial word vanishes without an error.
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    check("resync_ferr_b0", frame_err, 0);
    send_rest(8'h5A, 1'b0);
    check("resync_valid", prl_valid, 1);
    check("resync_out",   prl_out,   8'h5A);
    check("resync_ferr",  frame_err, 0);

    // Asynchronous reset in the middle of a frame.
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    srl_in = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out",   prl_out,   0);
    check("arst_valid", prl_valid, 0);
    check("arst_lock",  locked,    0);
    check("arst_ferr",  frame_err, 0);
    check("arst_ovr",   overrun,   0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_bit(1'b1, 1'b0);
    check("post_rst_lock", locked, 0);
    send_bit(1'b1, 1'b1);
    check("post_rst_lock_sync", locked, 1);
    send_rest(8'hC3, 1'b0);
    check("c3_valid", prl_valid, 1);
    check("c3_out",   prl_out,   8'hC3);
    check("c3_ferr",  frame_err, 0);
    send_bit(1'b0, 1'b0);
    check("c3_consumed", prl_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
